decoder2to4_hold: RTL and testbench



---
 rtl/decoder2to4_hold_if.sv | 31 +++
 rtl/decoder2to4_hold.sv | 104 ++++++++++
 tb/tb_decoder2to4_hold.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/decoder2to4_hold_if.sv
// Code link between the 4-to-2 encoder side (master) and the
// hold decoder (slave): 2-bit code + valid in, handshake, one-hot
// lines, overrun flag and per-line hit counts out.
interface decoder2to4_hold_if #(
  parameter int CNT_W = 8
);
  logic             a1;
  logic             a0;
  logic             v;
  logic             ready;
  logic             busy;
  logic             y0;
  logic             y1;
  logic             y2;
  logic             y3;
  logic             ovf;
  logic [CNT_W-1:0] hit0;
  logic [CNT_W-1:0] hit1;
  logic [CNT_W-1:0] hit2;
  logic [CNT_W-1:0] hit3;

  modport master (
    output a1, a0, v,
    input  ready, busy, y0, y1, y2, y3, ovf, hit0, hit1, hit2, hit3
  );

  modport slave (
    input  a1, a0, v,
    output ready, busy, y0, y1, y2, y3, ovf, hit0, hit1, hit2, hit3
  );
endinterface

// File: rtl/decoder2to4_hold.sv
// Registered 2-to-4 decoder with hold timer. An accepted code drives
// its one-hot line for HOLD_CYCLES cycles; a different code arriving
// during the hold sets a sticky overrun flag and is dropped.
// Optional macro DECODER2TO4_HIT_COUNT_EN builds saturating per-line
// accept counters; without it the hit ports are tied to zero.
module decoder2to4_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  decoder2to4_hold_if.slave bus
);
  localparam int TW = 8;  // HOLD_CYCLES tops out at 255

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    code_in;
  logic          accept;
  logic [3:0]    y_oh;

  assign code_in = {bus.a1, bus.a0};

  // Next-state: accept in IDLE, count down in HOLD, flag conflicts.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.v) begin
          accept  = 1'b1;
          code_d  = code_in;
          timer_d = TW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Same code repeated is expected: the encoder holds it steady.
        if (bus.v && (code_in != code_q)) ovf_d = 1'b1;
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any same-edge valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 2'b00;
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come only from flops, never straight from inputs.
  assign y_oh      = (state_q == HOLD) ? (4'b0001 << code_q) : 4'b0000;
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == HOLD);
  assign bus.y0    = y_oh[0];
  assign bus.y1    = y_oh[1];
  assign bus.y2    = y_oh[2];
  assign bus.y3    = y_oh[3];
  assign bus.ovf   = ovf_q;

`ifdef DECODER2TO4_HIT_COUNT_EN
  logic [3:0][CNT_W-1:0] hit_q;

  for (genvar g = 0; g < 4; g++) begin : g_hit
    // Saturating accept counter for line g.
    always_ff @(posedge clk) begin
      if (rst)
        hit_q[g] <= '0;
      else if (accept && (code_in == 2'(g)) && (hit_q[g] != '1))
        hit_q[g] <= hit_q[g] + 1'b1;
    end
  end

  assign bus.hit0 = hit_q[0];
  assign bus.hit1 = hit_q[1];
  assign bus.hit2 = hit_q[2];
  assign bus.hit3 = hit_q[3];
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.hit0 = '0;
  assign bus.hit1 = '0;
  assign bus.hit2 = '0;
  assign bus.hit3 = '0;
`endif
endmodule

// File: tb/tb_decoder2to4_hold.sv
// Bench for decoder2to4_hold (HOLD_CYCLES=4, CNT_W=2). Each driven cycle
// pushes the expected post-edge outputs into a scoreboard queue; the
// entry is popped and compared just after the edge.
module tb_decoder2to4_hold;
  localparam int HOLD  = 4;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       ovf;
    logic [3:0] y;
    logic [3:0][CNT_W-1:0] hit;
  } exp_t;

  logic clk;
  logic rst;
  decoder2to4_hold_if #(.CNT_W(CNT_W)) bus ();

  decoder2to4_hold #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model: cycles of hold remaining (0 = idle)
  int         m_left = 0;
  logic [1:0] m_code = 2'b00;
  logic       m_ovf  = 1'b0;
  int         m_hit[4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic vi, input logic [1:0] c);
    if (r) begin
      m_left = 0; m_code = 2'b00; m_ovf = 1'b0;
      for (int k = 0; k < 4; k++) m_hit[k] = 0;
    end else if (m_left == 0) begin
      if (vi) begin
        m_left = HOLD;
        m_code = c;
`ifdef DECODER2TO4_HIT_COUNT_EN
        if (m_hit[c] < SAT) m_hit[c] = m_hit[c] + 1;
`endif
      end
    end else begin
      if (vi && c != m_code) m_ovf = 1'b1;
      m_left = m_left - 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.busy  = (m_left > 0);
    e.ready = !e.busy;
    e.ovf   = m_ovf;
    e.y     = 4'b0000;
    if (e.busy) e.y[m_code] = 1'b1;
    for (int k = 0; k < 4; k++) e.hit[k] = CNT_W'(m_hit[k]);
    return e;
  endfunction

  task automatic step(input logic r, input logic vi, input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    rst    = r;
    bus.v  = vi;
    bus.a1 = c[1];
    bus.a0 = c[0];
    model_edge(r, vi, c);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("ready", {31'd0, bus.ready}, {31'd0, e.ready});
      chk("busy",  {31'd0, bus.busy},  {31'd0, e.busy});
      chk("ovf",   {31'd0, bus.ovf},   {31'd0, e.ovf});
      chk("y",     {28'd0, bus.y3, bus.y2, bus.y1, bus.y0}, {28'd0, e.y});
      chk("hit0",  32'(bus.hit0), 32'(e.hit[0]));
      chk("hit1",  32'(bus.hit1), 32'(e.hit[1]));
      chk("hit2",  32'(bus.hit2), 32'(e.hit[2]));
      chk("hit3",  32'(bus.hit3), 32'(e.hit[3]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b1; bus.v = 1'b0; bus.a1 = 1'b0; bus.a0 = 1'b0;

    // reset then idle
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    idle(2);

    // single decode of code 10, then return to idle
    step(1'b0, 1'b1, 2'b10);
    idle(6);

    // all four codes, 5 cycles apart
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 2'(k));
      idle(4);
    end
    idle(1);

    // HOLD_CYCLES... same code repeated during hold is silent
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b01);
    idle(4);
    chk("same_code_no_ovf", {31'd0, bus.ovf}, 32'd0);

    // overrun: accept 01, conflicting 11 two cycles later
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b11);
    idle(8);
    chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    // a later clean accept keeps ovf set
    step(1'b0, 1'b1, 2'b10);
    idle(5);

    // reset mid-hold, then a normal decode of 00
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b11);  // reset beats valid
    chk("rst_mid_y3", {31'd0, bus.y3}, 32'd0);
    step(1'b0, 1'b1, 2'b00);
    idle(5);

    // continuous valid, constant code: re-accept every HOLD+1
    for (int i = 0; i < 3 * (HOLD + 1); i++) step(1'b0, 1'b1, 2'b10);
    idle(5);

    // hit counter saturation on line 0
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'b00);
      idle(HOLD);
    end
`ifdef DECODER2TO4_HIT_COUNT_EN
    chk("hit0_sat", 32'(bus.hit0), 32'(SAT));
`else
    chk("hit0_off", 32'(bus.hit0), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4),
           2'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
